// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that streams host pixel words into the framebuffer RAM.
// Each cs_n-framed transaction is a start address followed by pixel words.
module spi_frame_loader #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 16,
    parameter int DEPTH  = 12288
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic [15:0] write_address,
    output logic [15:0] write_value,
    output logic        we,
    output logic        busy,
    output logic        frame_done,
    output logic        addr_error
);

    localparam logic [15:0] FRAME_LAST = 16'(WIDTH * HEIGHT - 1);
    localparam logic [15:0] DEPTH_LAST = 16'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        IGNORE
    } state_t;

    state_t state;
    state_t state_next;

    logic cs_s1;
    logic cs_s2;
    logic sck_s1;
    logic sck_s2;
    logic sck_q;
    logic mosi_s1;
    logic mosi_s2;

    logic [15:0] shift_q;
    logic [3:0]  bit_cnt;
    logic [15:0] pointer;

    logic        sck_rise;
    logic        shift_en;
    logic        word_done;
    logic        bit_clear;
    logic        addr_ok;
    logic        load_ptr;
    logic        data_word;
    logic        bad_addr;
    logic [15:0] word;

    // Idle values match a deselected bus so reset never fakes an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= spi_cs_n;
            cs_s2   <= cs_s1;
            sck_s1  <= spi_sck;
            sck_s2  <= sck_s1;
            sck_q   <= sck_s2;
            mosi_s1 <= spi_mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    always_comb begin
        sck_rise  = sck_s2 && !sck_q;
        shift_en  = sck_rise && (state == ADDR || state == DATA);
        word_done = shift_en && (bit_cnt == 4'd15);
        word      = {shift_q[14:0], mosi_s2};
        addr_ok   = (word <= DEPTH_LAST);
        load_ptr  = word_done && (state == ADDR) && addr_ok;
        bad_addr  = word_done && (state == ADDR) && !addr_ok;
        data_word = word_done && (state == DATA);
    end

    always_comb begin
        state_next = state;
        bit_clear  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!cs_s2) begin
                    state_next = ADDR;
                    bit_clear  = 1'b1;
                end
            end
            ADDR: begin
                if (word_done) begin
                    state_next = addr_ok ? DATA : IGNORE;
                end
            end
            DATA: begin
                state_next = DATA;
            end
            IGNORE: begin
                state_next = IGNORE;
            end
        endcase
        // Deselect wins; a word finishing this cycle is still committed below.
        if (state != IDLE && cs_s2) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= 16'd0;
            bit_cnt <= 4'd0;
        end else if (bit_clear) begin
            bit_cnt <= 4'd0;
        end else if (shift_en) begin
            shift_q <= word;
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pointer <= 16'd0;
        end else if (load_ptr) begin
            pointer <= word;
        end else if (data_word) begin
            pointer <= (pointer == DEPTH_LAST) ? 16'd0 : pointer + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            write_address <= 16'd0;
            write_value   <= 16'd0;
            we            <= 1'b0;
            frame_done    <= 1'b0;
            addr_error    <= 1'b0;
        end else begin
            we         <= data_word;
            addr_error <= bad_addr;
            frame_done <= data_word && (pointer == FRAME_LAST);
            if (data_word) begin
                write_address <= pointer;
                write_value   <= word;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_frame_loader.sv
// Bench for spi_frame_loader: table-driven SPI transactions with a write
// scoreboard, plus hand sequences for partial words and async reset.
module tb_spi_frame_loader;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck  = 1'b0;
    logic        spi_mosi = 1'b0;
    logic [15:0] write_address;
    logic [15:0] write_value;
    logic        we;
    logic        busy;
    logic        frame_done;
    logic        addr_error;

    always #5 clock = ~clock;

    spi_frame_loader dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .spi_cs_n      (spi_cs_n),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .write_address (write_address),
        .write_value   (write_value),
        .we            (we),
        .busy          (busy),
        .frame_done    (frame_done),
        .addr_error    (addr_error)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] v;
        logic        fd;
    } wr_t;

    typedef struct packed {
        logic [15:0]       addr;
        logic [1:0]        n;
        logic [2:0][15:0]  w;
        logic              err;
        logic [2:0][15:0]  ea;
        logic [2:0]        efd;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  got_q[$];
    vec_t vecs[5];

    int checks   = 0;
    int errors   = 0;
    int err_cnt  = 0;
    int stray_fd = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (we) got_q.push_back('{write_address, write_value, frame_done});
            if (addr_error) err_cnt++;
            if (frame_done && !we) stray_fd++;
        end
    end

    function automatic vec_t mk(
        input logic [15:0] addr, input int n,
        input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
        input logic err,
        input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
        input logic f0, input logic f1, input logic f2);
        vec_t r;
        r.addr   = addr;
        r.n      = 2'(n);
        r.w[0]   = w0;
        r.w[1]   = w1;
        r.w[2]   = w2;
        r.err    = err;
        r.ea[0]  = a0;
        r.ea[1]  = a1;
        r.ea[2]  = a2;
        r.efd[0] = f0;
        r.efd[1] = f1;
        r.efd[2] = f2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input int nb);
        for (int i = 15; i > 15 - nb; i--) begin
            spi_mosi = v[i];
            repeat (4) tick();
            spi_sck = 1'b1;
            repeat (4) tick();
            spi_sck = 1'b0;
        end
    endtask

    task automatic open_cs();
        spi_cs_n = 1'b0;
        repeat (4) tick();
    endtask

    task automatic close_cs(input string name);
        repeat (4) tick();
        chk({name, "_busy_hi"}, 64'(busy), 64'd1);
        spi_cs_n = 1'b1;
        repeat (5) tick();
        chk({name, "_busy_lo"}, 64'(busy), 64'd0);
        repeat (3) tick();
    endtask

    task automatic drain(input string name);
        wr_t e;
        wr_t g;
        while (exp_q.size() > 0 || got_q.size() > 0) begin
            if (got_q.size() == 0) begin
                e = exp_q.pop_front();
                chk({name, "_missing_write"}, 64'(e), 64'hF_FFFF_FFFF);
            end else if (exp_q.size() == 0) begin
                g = got_q.pop_front();
                chk({name, "_extra_write"}, 64'(g), 64'hF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                g = got_q.pop_front();
                chk({name, "_write"}, 64'(g), 64'(e));
            end
        end
    endtask

    initial begin
        int base;

        vecs[0] = mk(16'h0000, 3, 16'h0007, 16'h0003, 16'h0001, 1'b0,
                     16'd0, 16'd1, 16'd2, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(16'h01FF, 2, 16'h1111, 16'h2222, 16'h0000, 1'b0,
                     16'd511, 16'd512, 16'd0, 1'b1, 1'b0, 1'b0);
        vecs[2] = mk(16'h2FFF, 2, 16'hBEEF, 16'h0F0F, 16'h0000, 1'b0,
                     16'd12287, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        vecs[3] = mk(16'h3000, 3, 16'hDEAD, 16'hC0DE, 16'hFACE, 1'b1,
                     16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        vecs[4] = mk(16'h0020, 1, 16'h5A5A, 16'h0000, 16'h0000, 1'b0,
                     16'h0020, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        repeat (3) tick();
        chk("reset_outputs",
            64'({write_address, write_value, we, busy, frame_done, addr_error}), 64'd0);
        reset_n = 1'b1;
        repeat (4) tick();

        for (int k = 0; k < 5; k++) begin
            base = err_cnt;
            open_cs();
            send(vecs[k].addr, 16);
            for (int j = 0; j < int'(vecs[k].n); j++) begin
                send(vecs[k].w[j], 16);
                if (!vecs[k].err)
                    exp_q.push_back('{vecs[k].ea[j], vecs[k].w[j], vecs[k].efd[j]});
            end
            close_cs($sformatf("vec%0d", k));
            drain($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_addr_error", k), 64'(err_cnt - base), 64'(vecs[k].err));
        end

        open_cs();
        send(16'h0010, 16);
        send(16'hAAAA, 16);
        exp_q.push_back('{16'h0010, 16'hAAAA, 1'b0});
        send(16'h5555, 9);
        close_cs("partial");
        drain("partial");
        chk("partial_value_hold", 64'(write_value), 64'hAAAA);
        chk("partial_we_low", 64'(we), 64'd0);

        open_cs();
        send(16'h0040, 16);
        send(16'hFFFF, 8);
        spi_cs_n = 1'b1;
        reset_n  = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({write_address, write_value, we, busy, frame_done, addr_error}), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        drain("async_reset_nowrite");

        open_cs();
        send(16'h0005, 16);
        send(16'h1234, 16);
        exp_q.push_back('{16'h0005, 16'h1234, 1'b0});
        close_cs("post_reset");
        drain("post_reset");

        chk("stray_frame_done", 64'(stray_fd), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
